// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and the physical register index type for the windowed register file
package regfile_pkg;
    localparam int DATA_WIDTH  = 32;
    localparam int NUM_GLOBALS = 8;
    localparam int WIN_STRIDE  = 16;
    localparam int NWINDOWS    = 4;
    localparam int CWP_W       = $clog2(NWINDOWS);
    localparam int PHYS_REGS   = NUM_GLOBALS + WIN_STRIDE * NWINDOWS;
    typedef logic [6:0] phys_t;
endpackage

// File: rtl/regfile_addr_map.sv
// regfile_addr_map: maps (window, logical register) to a physical register index
module regfile_addr_map
    import regfile_pkg::*;
(
    input  logic [CWP_W-1:0] cwp,
    input  logic [4:0]       r,
    output phys_t            phys
);
    logic [CWP_W-1:0] cwp_next;
    assign cwp_next = cwp + 1'b1;
    assign phys = r[4:3] == 2'd0 ? phys_t'(r) :
                  r[4:3] == 2'd3 ? phys_t'({cwp_next, 4'b0}) + phys_t'(r) - phys_t'(WIN_STRIDE) :
                                   phys_t'({cwp, 4'b0}) + phys_t'(r);
endmodule

// File: rtl/sparc_windowed_regfile.sv
// sparc_windowed_regfile: 72-entry windowed register file, two combinational reads, one clocked write
module sparc_windowed_regfile
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rin,
    input  logic [CWP_W-1:0]      cwp,
    input  logic [4:0]            ra,
    input  logic [4:0]            rb,
    input  logic [4:0]            rc,
    input  logic                  rfe,
    output logic [DATA_WIDTH-1:0] aout,
    output logic [DATA_WIDTH-1:0] bout
);
    logic [DATA_WIDTH-1:0] regs [PHYS_REGS];
    phys_t pa, pb, pc;
    regfile_addr_map u_map_a (.cwp(cwp), .r(ra), .phys(pa));
    regfile_addr_map u_map_b (.cwp(cwp), .r(rb), .phys(pb));
    regfile_addr_map u_map_c (.cwp(cwp), .r(rc), .phys(pc));
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHYS_REGS; i++) regs[i] <= '0;
        end else if (!rfe) begin
            regs[pc] <= rin;
        end
    end
    assign aout = regs[pa];
    assign bout = regs[pb];
endmodule

// File: tb/tb_sparc_windowed_regfile.sv
// tb_sparc_windowed_regfile: directed and randomized checks against a window-semantics reference model
module tb_sparc_windowed_regfile;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rin = '0;
    logic [1:0]  cwp = '0;
    logic [4:0]  ra = '0, rb = '0, rc = '0;
    logic        rfe = 1'b1;
    logic [31:0] aout, bout;
    logic [31:0] model [72];
    int n_cmp = 0;
    int n_err = 0;

    sparc_windowed_regfile dut (
        .clk(clk), .reset(reset), .rin(rin), .cwp(cwp), .ra(ra), .rb(rb),
        .rc(rc), .rfe(rfe), .aout(aout), .bout(bout)
    );

    always #5 clk = ~clk;

    function automatic int phys(input int w, input int r);
        if (r < 8)  return r;
        if (r < 16) return 8 + 16 * w + (r - 8);
        if (r < 24) return 16 + 16 * w + (r - 16);
        return 8 + 16 * ((w + 1) % 4) + (r - 24);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        rfe = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 72; i++) model[i] = '0;
    endtask

    task automatic do_write(input int w, input int r, input logic [31:0] d);
        cwp = 2'(w);
        rc = 5'(r);
        rin = d;
        rfe = 1'b0;
        @(posedge clk);
        #1;
        rfe = 1'b1;
        if (!reset) model[phys(w, r)] = d;
    endtask

    task automatic test_reset();
        do_reset();
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 32; r++) begin
                cwp = 2'(w);
                ra = 5'(r);
                rb = 5'(31 - r);
                #1;
                n_cmp += 2;
                if (aout !== 32'h0) begin
                    n_err++;
                    $display("FAIL reset_a w=%0d r=%0d: got %h want 0", w, r, aout);
                end
                if (bout !== 32'h0) begin
                    n_err++;
                    $display("FAIL reset_b w=%0d r=%0d: got %h want 0", w, 31 - r, bout);
                end
            end
    endtask

    task automatic test_global();
        do_write(0, 0, 32'h00001111);
        cwp = 2'd0;
        ra = 5'd0;
        #1;
        n_cmp++;
        if (aout !== 32'h00001111) begin
            n_err++;
            $display("FAIL global_r0: got %h want 00001111", aout);
        end
    endtask

    task automatic test_overlap();
        do_write(1, 29, 32'h00001111);
        cwp = 2'd2;
        rb = 5'd13;
        #1;
        n_cmp++;
        if (bout !== 32'h00001111) begin
            n_err++;
            $display("FAIL overlap_w2r13: got %h want 00001111", bout);
        end
    endtask

    task automatic test_wrap();
        do_write(3, 29, 32'hCAFEF00D);
        cwp = 2'd0;
        rb = 5'd13;
        #1;
        n_cmp++;
        if (bout !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL wrap_w0r13: got %h want cafef00d", bout);
        end
    endtask

    task automatic test_isolation();
        do_write(0, 17, 32'h12345678);
        for (int w = 0; w < 4; w++) begin
            cwp = 2'(w);
            ra = 5'd17;
            #1;
            n_cmp++;
            if (aout !== (w == 0 ? 32'h12345678 : 32'h0)) begin
                n_err++;
                $display("FAIL isolation_r17 w=%0d: got %h", w, aout);
            end
        end
        do_write(2, 5, 32'hA5A5A5A5);
        for (int w = 0; w < 4; w++) begin
            cwp = 2'(w);
            rb = 5'd5;
            #1;
            n_cmp++;
            if (bout !== 32'hA5A5A5A5) begin
                n_err++;
                $display("FAIL global_r5 w=%0d: got %h want a5a5a5a5", w, bout);
            end
        end
    endtask

    task automatic test_write_disable();
        cwp = 2'd0;
        rc = 5'd20;
        rin = 32'hFFFFFFFF;
        rfe = 1'b1;
        @(posedge clk);
        #1;
        ra = 5'd20;
        #1;
        n_cmp++;
        if (aout !== 32'h0) begin
            n_err++;
            $display("FAIL write_disable_r20: got %h want 0", aout);
        end
    endtask

    task automatic test_reset_priority();
        do_write(0, 0, 32'h0BADF00D);
        cwp = 2'd0;
        rc = 5'd0;
        rin = 32'hDEADBEEF;
        rfe = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rfe = 1'b1;
        for (int i = 0; i < 72; i++) model[i] = '0;
        for (int k = 0; k < 3; k++) begin
            cwp = k == 2 ? 2'd2 : 2'd0;
            ra = k == 0 ? 5'd0 : 5'd13;
            rb = k == 0 ? 5'd0 : 5'd13;
            #1;
            n_cmp += 2;
            if (aout !== 32'h0 || bout !== 32'h0) begin
                n_err++;
                $display("FAIL reset_priority k=%0d: a=%h b=%h want 0", k, aout, bout);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            int w, r;
            logic [31:0] d;
            logic we;
            w = int'($urandom_range(3));
            r = int'($urandom_range(31));
            d = $urandom;
            we = $urandom_range(3) != 0;
            cwp = 2'(w);
            rc = 5'(r);
            ra = 5'(r);
            rin = d;
            rfe = !we;
            #1;
            n_cmp++;
            if (aout !== model[phys(w, r)]) begin
                n_err++;
                $display("FAIL rdw_old it=%0d: got %h want %h", it, aout, model[phys(w, r)]);
            end
            @(posedge clk);
            #1;
            rfe = 1'b1;
            if (we) model[phys(w, r)] = d;
            w = int'($urandom_range(3));
            cwp = 2'(w);
            ra = 5'($urandom_range(31));
            rb = $urandom_range(1) ? ra : 5'($urandom_range(31));
            #1;
            n_cmp += 2;
            if (aout !== model[phys(w, int'(ra))]) begin
                n_err++;
                $display("FAIL rand_a it=%0d w=%0d r=%0d: got %h want %h", it, w, ra, aout, model[phys(w, int'(ra))]);
            end
            if (bout !== model[phys(w, int'(rb))]) begin
                n_err++;
                $display("FAIL rand_b it=%0d w=%0d r=%0d: got %h want %h", it, w, rb, bout, model[phys(w, int'(rb))]);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_global();
        test_overlap();
        test_wrap();
        test_isolation();
        test_write_disable();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
